alu_mdu: RTL
============

ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; legal values 8..64, even.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  operation request.
REQ-005 SHALL have port in_ready  output  1  unit can accept a request.
REQ-006 SHALL have port op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 SHALL have ports a, b  input  XLEN each  operands, rs1/rs2.
REQ-008 SHALL have port flush  input  1  abort in-flight operation.
REQ-009 SHALL have port out_valid  output  1  result available.
REQ-010 SHALL have port out_ready  input  1  consumer takes result.
REQ-011 SHALL have port result  output  XLEN  operation result.
REQ-012 SHALL have port zero  output  1  result == 0, valid only while out_valid.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE; in_ready = 1 only in IDLE.
REQ-014 SHALL accept a request when in_valid && in_ready at a rising edge, latching op, a, b and operand signs.
REQ-015 SHALL, after accepting a normal op, go IDLE->BUSY, stay in BUSY exactly XLEN cycles (one bit per cycle), then enter DONE; out_valid first high XLEN+1 cycles after the accept edge.
REQ-016 SHALL multiply by shift-add on 2*XLEN-bit product of operand magnitudes, negating the product when signs differ; MUL returns low XLEN bits, MULH/MULHSU/MULHU high XLEN bits.
REQ-017 SHALL treat operands as: MULH signed*signed, MULHSU signed a * unsigned b, MULHU and DIVU/REMU unsigned, DIV/REM signed.
REQ-018 SHALL divide by restoring division on magnitudes; quotient sign = sign(a) xor sign(b); remainder sign = sign(a).
REQ-019 SHALL handle divide-by-zero (b == 0) without BUSY: DIV/DIVU result all ones, REM/REMU result a; out_valid high 1 cycle after accept.
REQ-020 SHALL handle signed overflow (DIV/REM, a = -2^(XLEN-1), b = -1) without BUSY: DIV result a, REM result 0; out_valid 1 cycle after accept.
REQ-021 SHALL hold out_valid, result and zero stable in DONE until out_valid && out_ready, then return to IDLE on that edge.
REQ-022 SHALL not accept a new request in the cycle the result is consumed (in_ready low in DONE); earliest next accept is the following cycle.
REQ-023 SHALL, when flush is high at an edge, go to IDLE from any state, discard the in-flight result and drop out_valid next cycle; flush has priority over acceptance and consumption in the same cycle.
REQ-024 SHALL ignore op, a, b changes while not in IDLE.
REQ-025 SHALL drive result to 0 and zero to 0 whenever out_valid is low.

Reset
REQ-026 SHALL, with rst high at an edge, enter IDLE and clear all datapath registers; rst has priority over flush and requests.
REQ-027 SHALL present after reset: in_ready = 1, out_valid = 0, result = 0, zero = 0.
REQ-028 SHALL abandon any operation in flight when rst asserts mid-BUSY or in DONE, with no result delivered.

Verification (XLEN = 32)
REQ-029 SHALL verify MUL a=7, b=-3 -> result 0xFFFFFFEB, out_valid at accept+33, zero=0; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
REQ-030 SHALL verify DIV a=-7, b=2 -> 0xFFFFFFFD; REM a=-7, b=2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-031 SHALL verify DIVU a=5, b=0 -> 0xFFFFFFFF and REM a=5, b=0 -> 5, both out_valid at accept+1; DIV 0x80000000/-1 -> 0x80000000, REM -> 0 with zero=1.
REQ-032 SHALL verify backpressure: out_ready held low 10 cycles after DONE -> out_valid and result stable, in_ready low; out_ready high -> IDLE next cycle, next accept one cycle later.
REQ-033 SHALL verify flush asserted at BUSY cycle 5 -> IDLE next cycle, out_valid never asserted, subsequent MUL 3*4 returns 12.
REQ-034 SHALL verify rst asserted mid-BUSY -> next cycle in_ready=1, out_valid=0, result=0, and no stale result ever appears.

Source files
------------

// File: rtl/alu_mdu_if.sv
// Request/response bundle between an RV32M-style multiply/divide unit and its user.
// The master side issues operations and consumes results; the slave side is the unit.
interface alu_mdu_if #(
  parameter int XLEN = 32
) ();
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            zero;

  modport master (
    output in_valid, op, a, b, flush, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, op, a, b, flush, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/alu_mdu.sv
// Iterative multiply/divide unit: shift-add multiply and restoring divide on operand
// magnitudes, one bit per cycle, with single-cycle handling of divide-by-zero and overflow.
module alu_mdu #(
  parameter int XLEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  alu_mdu_if.slave    bus
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_n;

  logic [XLEN-1:0] hi, lo, b_mag_q, res_q;
  logic [CW-1:0]   count;
  logic            is_div_q, rem_sel_q, mul_high_q, neg_q, neg_rem_q;

  // Request decode
  logic            accept, sign_a, sign_b, div_zero, div_ovf, special;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  always_comb begin
    accept      = bus.in_valid && (state == IDLE);
    sign_a      = (bus.op == 3'b001 || bus.op == 3'b010 || bus.op == 3'b100 ||
                   bus.op == 3'b110) && bus.a[XLEN-1];
    sign_b      = (bus.op == 3'b001 || bus.op == 3'b100 || bus.op == 3'b110) &&
                  bus.b[XLEN-1];
    a_mag       = sign_a ? -bus.a : bus.a;
    b_mag       = sign_b ? -bus.b : bus.b;
    div_zero    = bus.op[2] && (bus.b == '0);
    div_ovf     = bus.op[2] && !bus.op[0] && (bus.b == '1) &&
                  (bus.a == {1'b1, {(XLEN-1){1'b0}}});
    special     = div_zero || div_ovf;
    special_res = '0;
    if (div_zero) special_res = bus.op[1] ? bus.a : '1;
    else          special_res = bus.op[1] ? '0 : bus.a;
  end

  // One iteration step; divide reuses hi as partial remainder and lo as dividend/quotient
  logic [XLEN:0]     mul_sum, shifted, diff;
  logic [XLEN-1:0]   hi_n, lo_n, quo, rem;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   final_res;
  logic              last;

  always_comb begin
    mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, b_mag_q} : '0);
    shifted = {hi, lo[XLEN-1]};
    diff    = shifted - {1'b0, b_mag_q};
    if (is_div_q) begin
      hi_n = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      lo_n = {lo[XLEN-2:0], ~diff[XLEN]};
    end else begin
      hi_n = mul_sum[XLEN:1];
      lo_n = {mul_sum[0], lo[XLEN-1:1]};
    end
    prod      = {hi_n, lo_n};
    prod_s    = neg_q ? -prod : prod;
    quo       = neg_q ? -lo_n : lo_n;
    rem       = neg_rem_q ? -hi_n : hi_n;
    final_res = '0;
    if (is_div_q) final_res = rem_sel_q ? rem : quo;
    else          final_res = mul_high_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
    last      = (count == CW'(XLEN-1));
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (bus.in_valid) state_n = special ? DONE : BUSY;
      BUSY:    if (last) state_n = DONE;
      DONE:    if (bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (bus.flush) state_n = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi         <= '0;
      lo         <= '0;
      b_mag_q    <= '0;
      res_q      <= '0;
      count      <= '0;
      is_div_q   <= 1'b0;
      rem_sel_q  <= 1'b0;
      mul_high_q <= 1'b0;
      neg_q      <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else if (bus.flush) begin
      res_q <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          hi         <= '0;
          lo         <= a_mag;
          b_mag_q    <= b_mag;
          count      <= '0;
          is_div_q   <= bus.op[2];
          rem_sel_q  <= bus.op[1];
          mul_high_q <= (bus.op[1:0] != 2'b00);
          neg_q      <= sign_a ^ sign_b;
          neg_rem_q  <= sign_a;
          res_q      <= special ? special_res : '0;
        end
        BUSY: begin
          hi    <= hi_n;
          lo    <= lo_n;
          count <= count + CW'(1);
          if (last) res_q <= final_res;
        end
        DONE: if (bus.out_ready) res_q <= '0;
        default: res_q <= '0;
      endcase
    end
  end

  // Result is forced to zero outside DONE so nothing stale leaks to the consumer
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
    bus.result    = bus.out_valid ? res_q : '0;
    bus.zero      = bus.out_valid && (res_q == '0);
  end

endmodule
